// File: rtl/match_run_monitor.sv
// Registered statistics/alarm stage behind the 00/11 detector: counts match runs, tracks run lengths, sticky alarm.
// Build option: define MATCH_RUN_SAT_EN to saturate hit_cnt/run_len instead of wrapping.
module match_run_monitor #(
  parameter int CNT_W  = 8,
  parameter int RUN_TH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z,
  input  logic             clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] max_run,
  output logic             rise_pulse,
  output logic             alarm
);

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH      = CNT_W'(RUN_TH);

  state_t           state, state_nx;
  logic             z_q;
  logic             rise;
  logic [CNT_W-1:0] run_nx, hit_nx, max_nx;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
`ifdef MATCH_RUN_SAT_EN
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  always_comb begin
    rise     = z & ~z_q;
    run_nx   = z ? inc(run_len) : '0;
    hit_nx   = rise ? inc(hit_cnt) : hit_cnt;
    max_nx   = (run_nx > max_run) ? run_nx : max_run;
    state_nx = state;
    unique case (state)
      IDLE:    if (z) state_nx = (run_nx == TH) ? ALARM : RUN;
      RUN:     if (!z) state_nx = IDLE;
               else if (run_nx == TH) state_nx = ALARM;
      ALARM:   state_nx = ALARM;  // sticky; only rst/clr leave
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state      <= IDLE;
      z_q        <= 1'b0;
      hit_cnt    <= '0;
      run_len    <= '0;
      max_run    <= '0;
      rise_pulse <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nx;
      z_q        <= z;
      hit_cnt    <= hit_nx;
      run_len    <= run_nx;
      max_run    <= max_nx;
      rise_pulse <= rise;
      alarm      <= (state_nx == ALARM);
    end
  end

endmodule

// File: tb/tb_match_run_monitor.sv
// Directed bench for match_run_monitor: CNT_W=8 instance for function, CNT_W=4 instance for width limits.
module tb_match_run_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, z, clr;
  logic [7:0] hit_cnt, run_len, max_run;
  logic       rise_pulse, alarm;

  logic       rst4, z4, clr4;
  logic [3:0] hit4, run4, max4;
  logic       rp4, al4;

  int tests = 0;
  int fails = 0;

`ifdef MATCH_RUN_SAT_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  match_run_monitor #(.CNT_W(8), .RUN_TH(3)) dut (
    .clk(clk), .rst(rst), .z(z), .clr(clr),
    .hit_cnt(hit_cnt), .run_len(run_len), .max_run(max_run),
    .rise_pulse(rise_pulse), .alarm(alarm)
  );

  match_run_monitor #(.CNT_W(4), .RUN_TH(3)) dut4 (
    .clk(clk), .rst(rst4), .z(z4), .clr(clr4),
    .hit_cnt(hit4), .run_len(run4), .max_run(max4),
    .rise_pulse(rp4), .alarm(al4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkall(input string tag, input int h, input int r, input int m,
                        input int rp, input int al);
    chk({tag, ".hit_cnt"}, {24'd0, hit_cnt}, h);
    chk({tag, ".run_len"}, {24'd0, run_len}, r);
    chk({tag, ".max_run"}, {24'd0, max_run}, m);
    chk({tag, ".rise_pulse"}, {31'd0, rise_pulse}, rp);
    chk({tag, ".alarm"}, {31'd0, alarm}, al);
  endtask

  initial begin
    rst = 1'b1; z = 1'b0; clr = 1'b0;
    rst4 = 1'b1; z4 = 1'b0; clr4 = 1'b0;

    // reset with z toggling
    z = 1'b1; tick(); chkall("rst0", 0, 0, 0, 0, 0);
    z = 1'b0; tick(); chkall("rst1", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // runs: z = 0,1,0,1,1,0
    z = 1'b0; tick(); chkall("run_e1", 0, 0, 0, 0, 0);
    z = 1'b1; tick(); chkall("run_e2", 1, 1, 1, 1, 0);
    z = 1'b0; tick(); chkall("run_e3", 1, 0, 1, 0, 0);
    z = 1'b1; tick(); chkall("run_e4", 2, 1, 1, 1, 0);
    z = 1'b1; tick(); chkall("run_e5", 2, 2, 2, 0, 0);
    z = 1'b0; tick(); chkall("run_e6", 2, 0, 2, 0, 0);

    // alarm on the third consecutive 1
    z = 1'b1; tick(); chkall("alm_e1", 3, 1, 2, 1, 0);
    z = 1'b1; tick(); chkall("alm_e2", 3, 2, 2, 0, 0);
    z = 1'b1; tick(); chkall("alm_e3", 3, 3, 3, 0, 1);
    z = 1'b0; tick(); chkall("alm_e4", 3, 0, 3, 0, 1);
    repeat (4) tick();
    chkall("alm_hold", 3, 0, 3, 0, 1);

    // clear with z held high; next edge is a fresh rise
    z = 1'b1; clr = 1'b1; tick(); chkall("clr", 0, 0, 0, 0, 0);
    clr = 1'b0; tick(); chkall("clr_next", 1, 1, 1, 1, 0);

    // reset mid-run with clr also asserted
    tick(); chkall("mid_e2", 1, 2, 2, 0, 0);
    rst = 1'b1; clr = 1'b1; tick(); chkall("mid_rst", 0, 0, 0, 0, 0);
    rst = 1'b0; clr = 1'b0; tick(); chkall("mid_next", 1, 1, 1, 1, 0);

    // width limit on CNT_W=4 instance
    rst4 = 1'b0; z4 = 1'b1;
    repeat (15) tick();
    chk("w4_run15", {28'd0, run4}, 15);
    tick();
    chk("w4_run16", {28'd0, run4}, SAT ? 15 : 0);
    chk("w4_max16", {28'd0, max4}, 15);
    repeat (4) tick();
    chk("w4_run20", {28'd0, run4}, SAT ? 15 : 4);
    chk("w4_max20", {28'd0, max4}, 15);
    chk("w4_hit20", {28'd0, hit4}, 1);
    chk("w4_alarm", {31'd0, al4}, 1);
    chk("w4_rp", {31'd0, rp4}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
